// File: rtl/move_list_if.sv
// Handshake and bus bundle between the square-cell move bus, the collector
// and the downstream search engine.
interface move_list_if #(
    parameter int NUM_SQ = 2,
    parameter int DIRS   = 16,
    parameter int MOVE_W = 32
);
    localparam int CNT_W = $clog2(NUM_SQ * DIRS + 1);

    logic                            enable;
    logic                            start;
    logic                            captures_only;
    logic [NUM_SQ*DIRS*MOVE_W-1:0]   move_bus;
    logic [MOVE_W-1:0]               out_move;
    logic                            out_valid;
    logic                            out_ready;
    logic                            busy;
    logic                            done;
    logic [CNT_W-1:0]                move_count;

    modport slave (
        input  enable, start, captures_only, move_bus, out_ready,
        output out_move, out_valid, busy, done, move_count
    );

    modport master (
        output enable, start, captures_only, move_bus, out_ready,
        input  out_move, out_valid, busy, done, move_count
    );
endinterface

// File: rtl/move_list_collector.sv
// Snapshots the square-cell move bus, scans slots in index order, filters
// empty (and optionally non-capture) moves and streams survivors through a FIFO.
module move_list_collector #(
    parameter int NUM_SQ     = 2,
    parameter int DIRS       = 16,
    parameter int MOVE_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           clear,
    move_list_if.slave     ml
);
    localparam int SLOTS  = NUM_SQ * DIRS;
    localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W  = $clog2(SLOTS + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int CAP_HI = 29;
    localparam int CAP_LO = 24;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t             state;
    state_t             state_n;
    logic [MOVE_W-1:0]  snap [SLOTS];
    logic [MOVE_W-1:0]  mem  [FIFO_DEPTH];
    logic               cap_only;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;

    logic [MOVE_W-1:0]  cur_word;
    logic               take_start;
    logic               scan_eval;
    logic               is_skip;
    logic               full;
    logic               push;
    logic               pop;
    logic               advance;
    logic               last;

    assign cur_word   = snap[idx];
    assign take_start = (state == IDLE) && ml.start;
    assign scan_eval  = (state == SCAN) && ml.enable;
    assign is_skip    = (cur_word == '0) || (cap_only && (cur_word[CAP_HI:CAP_LO] == '0));
    assign full       = (occ == OCC_W'(FIFO_DEPTH));
    // A pushable word never bypasses a full FIFO, even if the head pops this cycle.
    assign push       = scan_eval && !is_skip && !full;
    assign advance    = scan_eval && (is_skip || !full);
    assign last       = (idx == IDX_W'(SLOTS - 1));
    assign pop        = ml.out_valid && ml.out_ready;

    assign ml.out_valid  = (occ != '0);
    assign ml.out_move   = ml.out_valid ? mem[rd_ptr] : '0;
    assign ml.busy       = (state == SCAN) || (state == DRAIN);
    assign ml.done       = (state == DONE);
    assign ml.move_count = count;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (ml.start) state_n = SCAN;
            SCAN:    if (advance && last) state_n = DRAIN;
            DRAIN:   if (occ == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            cap_only <= 1'b0;
            idx      <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            state <= state_n;
            if (take_start) begin
                cap_only <= ml.captures_only;
                idx      <= '0;
                count    <= '0;
            end else begin
                if (advance)
                    idx <= last ? '0 : idx + 1'b1;
                if (push && (count != CNT_W'(SLOTS)))
                    count <= count + 1'b1;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Snapshot and FIFO storage carry no reset; validity is tracked by occ.
    always_ff @(posedge clk) begin
        if (take_start) begin
            for (int i = 0; i < SLOTS; i++)
                snap[i] <= ml.move_bus[i*MOVE_W +: MOVE_W];
        end
        if (push)
            mem[wr_ptr] <= cur_word;
    end
endmodule

// File: tb/tb_move_list_collector.sv
// Bench for move_list_collector: directed vector table, hand-written corner
// sequences and randomised scans scored against a filter-and-queue model.
module tb_move_list_collector;
    localparam int NUM_SQ     = 2;
    localparam int DIRS       = 16;
    localparam int MOVE_W     = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int SLOTS      = NUM_SQ * DIRS;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    move_list_if #(.NUM_SQ(NUM_SQ), .DIRS(DIRS), .MOVE_W(MOVE_W)) ml ();

    move_list_collector #(
        .NUM_SQ(NUM_SQ), .DIRS(DIRS), .MOVE_W(MOVE_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .clear(clear),
        .ml(ml)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] bus_arr [SLOTS];

    typedef struct {
        logic [31:0] word;
        int          slot;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        string       name;
        logic        cap;
        int          sa;
        logic [31:0] wa;
        int          sb;
        logic [31:0] wb;
        int          exp_cnt;
        int          exp_done;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference: every nonzero word, in slot order, minus non-captures in captures-only mode.
    task automatic build_model(input logic cap);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < SLOTS; i++) begin
            if (bus_arr[i] != 32'h0 && !(cap && bus_arr[i][29:24] == 6'h0)) begin
                e.word = bus_arr[i];
                e.slot = i;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_scan(input logic cap);
        build_model(cap);
        for (int i = 0; i < SLOTS; i++)
            ml.move_bus[i*MOVE_W +: MOVE_W] = bus_arr[i];
        ml.captures_only = cap;
        ml.enable        = 1'b1;
        ml.start         = 1'b1;
        @(posedge clk);
        #1;
        ml.start         = 1'b0;
        ml.captures_only = 1'($urandom_range(1));
    endtask

    task automatic drain_check(input string nm, input int first_cycle, input int en_pct,
                               input int rdy_pct, input int frz_lo, input int frz_hi,
                               input int restart_cyc, input bit chk_timing,
                               input int exp_done, input int exp_cnt);
        int   cycle     = first_cycle;
        int   done_seen = 0;
        int   done_cyc  = 0;
        int   done_hits = 0;
        exp_t e;
        while (done_seen == 0 && cycle < first_cycle + 3000) begin
            ml.enable    = (cycle >= frz_lo && cycle <= frz_hi) ? 1'b0
                         : (int'($urandom_range(99)) < en_pct);
            ml.out_ready = (int'($urandom_range(99)) < rdy_pct);
            if (cycle == restart_cyc) begin
                ml.start = 1'b1;
                for (int i = 0; i < SLOTS; i++)
                    ml.move_bus[i*MOVE_W +: MOVE_W] = 32'h200 + i;
            end else begin
                ml.start = 1'b0;
            end
            if (cycle == first_cycle)
                chk_int({nm, " busy"}, int'(ml.busy), 1);
            if (ml.done) begin
                done_seen = 1;
                done_cyc  = cycle;
            end else if (ml.out_valid && ml.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s extra_word actual=%h required=none", nm, ml.out_move);
                end else begin
                    e = exp_q.pop_front();
                    chk({nm, " word"}, ml.out_move, e.word);
                    if (chk_timing)
                        chk_int({nm, " word_cycle"}, cycle, e.slot + 2);
                end
            end
            @(posedge clk);
            #1;
            cycle++;
        end
        ml.start = 1'b0;
        chk_int({nm, " done_seen"}, done_seen, 1);
        if (exp_done > 0)
            chk_int({nm, " done_cycle"}, done_cyc, exp_done);
        chk_int({nm, " words_left"}, exp_q.size(), 0);
        chk_int({nm, " move_count"}, int'(ml.move_count), exp_cnt);
        for (int k = 0; k < 3; k++) begin
            if (ml.done) done_hits++;
            @(posedge clk);
            #1;
        end
        chk_int({nm, " single_done"}, done_hits, 0);
        chk_int({nm, " count_hold"}, int'(ml.move_count), exp_cnt);
    endtask

    task automatic set_basic_bus();
        foreach (bus_arr[i]) bus_arr[i] = 32'h0;
        bus_arr[2]  = 32'h001C1814;
        bus_arr[19] = 32'h30151816;
    endtask

    initial begin
        int done_hits;
        int valid_hits;

        tbl[0] = '{"basic",      1'b0,  2, 32'h001C1814, 19, 32'h30151816, 2, 34};
        tbl[1] = '{"capt_only",  1'b1,  2, 32'h001C1814, 19, 32'h30151816, 1, 34};
        tbl[2] = '{"empty",      1'b0, -1, 32'h0,        -1, 32'h0,        0, 34};
        tbl[3] = '{"capt_edge",  1'b1,  0, 32'h00050403, 31, 32'h01000000, 1, 35};
        tbl[4] = '{"last_slot",  1'b0, -1, 32'h0,        31, 32'hFFFFFFFF, 1, 35};
        tbl[5] = '{"first_two",  1'b0,  0, 32'h00000001,  1, 32'h3F3F3F3F, 2, 34};

        // Reset with noisy inputs
        clear            = 1'b1;
        ml.start         = 1'b1;
        ml.enable        = 1'($urandom_range(1));
        ml.captures_only = 1'($urandom_range(1));
        ml.out_ready     = 1'($urandom_range(1));
        for (int i = 0; i < SLOTS; i++)
            ml.move_bus[i*MOVE_W +: MOVE_W] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid",  {31'h0, ml.out_valid}, 32'h0);
        chk("reset busy",       {31'h0, ml.busy},      32'h0);
        chk("reset done",       {31'h0, ml.done},      32'h0);
        chk_int("reset move_count", int'(ml.move_count), 0);
        chk("reset out_move",   ml.out_move,           32'h0);
        clear    = 1'b0;
        ml.start = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int t = 0; t < 6; t++) begin
            foreach (bus_arr[i]) bus_arr[i] = 32'h0;
            if (tbl[t].sa >= 0) bus_arr[tbl[t].sa] = tbl[t].wa;
            if (tbl[t].sb >= 0) bus_arr[tbl[t].sb] = tbl[t].wb;
            start_scan(tbl[t].cap);
            drain_check(tbl[t].name, 1, 100, 100, -1, -1, -1, 1'b1,
                        tbl[t].exp_done, tbl[t].exp_cnt);
        end

        // Backpressure: FIFO fills with slots 0..7 and the scan stalls at 8
        foreach (bus_arr[i]) bus_arr[i] = 32'h100 + i;
        start_scan(1'b0);
        ml.out_ready = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk_int("bp stall_count", int'(ml.move_count), 8);
        chk("bp out_valid", {31'h0, ml.out_valid}, 32'h1);
        chk("bp busy",      {31'h0, ml.busy},      32'h1);
        chk("bp head",      ml.out_move,           32'h100);
        drain_check("bp", 21, 100, 100, -1, -1, -1, 1'b0, 0, 32);

        // start while busy is ignored
        set_basic_bus();
        start_scan(1'b0);
        drain_check("restart", 1, 100, 100, -1, -1, 10, 1'b1, 34, 2);

        // enable low for cycles 3..7
        set_basic_bus();
        start_scan(1'b0);
        drain_check("freeze", 1, 100, 100, 3, 7, -1, 1'b0, 39, 2);

        // clear mid-scan aborts without a done pulse
        set_basic_bus();
        start_scan(1'b0);
        ml.out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("abort busy",      {31'h0, ml.busy},      32'h0);
        chk("abort out_valid", {31'h0, ml.out_valid}, 32'h0);
        chk("abort out_move",  ml.out_move,           32'h0);
        chk_int("abort move_count", int'(ml.move_count), 0);
        done_hits    = 0;
        valid_hits   = 0;
        ml.out_ready = 1'b1;
        repeat (40) begin
            if (ml.done)      done_hits++;
            if (ml.out_valid) valid_hits++;
            @(posedge clk);
            #1;
        end
        chk_int("abort no_done",  done_hits,  0);
        chk_int("abort no_valid", valid_hits, 0);
        exp_q.delete();

        // Randomised scans with random enable/ready
        for (int it = 0; it < 25; it++) begin
            logic        cap;
            logic [31:0] w;
            for (int i = 0; i < SLOTS; i++) begin
                w = $urandom;
                case ($urandom_range(3))
                    0:       bus_arr[i] = 32'h0;
                    1:       bus_arr[i] = (w & 32'hC0FF_FFFF) | 32'h1;
                    default: bus_arr[i] = w;
                endcase
            end
            cap = 1'($urandom_range(1));
            start_scan(cap);
            drain_check("rand", 1, 70, 60, -1, -1, -1, 1'b0, 0, exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
